// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for a CPU load/store port.
// Each access runs IDLE -> READ (-> WRITE) -> DONE; stores are read-modify-write on a single-port RAM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic        clk_stall,
  output logic        err
);

  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      mask_q, mask_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     merge_q, merge_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            stall_q, stall_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [31:0]     ram_rdata_q;
  logic            ram_we_c;
  logic [AW-1:0]   ram_idx_c;
  logic [31:0]     merged_c;
  logic [31:0]     load_fmt_c;
  logic [32:0]     diff_c;
  logic            in_range_c;
  logic            misaligned_c;

  // Range check uses a 33-bit difference so addresses below BASE_ADDR wrap far above SPAN
  always_comb begin
    diff_c       = {1'b0, addr} - {1'b0, BASE_ADDR};
    in_range_c   = (diff_c < SPAN);
    misaligned_c = 1'b0;
    if (sign_mask[2:0] == 3'b011)      misaligned_c = addr[0];
    else if (sign_mask[2:0] != 3'b001) misaligned_c = (addr[1:0] != 2'b00);
  end

  // Lane merge: replicate the store data across lanes, then enable only the addressed ones
  always_comb begin
    logic [31:0] rep;
    logic [3:0]  en;
    if (mask_q[2:0] == 3'b001) begin
      rep = {4{wdata_q[7:0]}};
      en  = 4'b0001 << lane_q;
    end else if (mask_q[2:0] == 3'b011) begin
      rep = {2{wdata_q[15:0]}};
      en  = lane_q[1] ? 4'b1100 : 4'b0011;
    end else begin
      rep = wdata_q;
      en  = 4'b1111;
    end
    merged_c = merge_q;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) merged_c[8*i +: 8] = rep[8*i +: 8];
    end
  end

  always_comb begin
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = ram_rdata_q[{lane_q, 3'b000} +: 8];
    h16 = ram_rdata_q[{lane_q[1], 4'b0000} +: 16];
    if (mask_q[2:0] == 3'b001)      load_fmt_c = {{24{mask_q[3] & b8[7]}}, b8};
    else if (mask_q[2:0] == 3'b011) load_fmt_c = {{16{mask_q[3] & h16[15]}}, h16};
    else                            load_fmt_c = ram_rdata_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    is_wr_d     = is_wr_q;
    merge_d     = merge_q;
    read_data_d = read_data_q;
    stall_d     = 1'b0;
    err_d       = 1'b0;
    ram_we_c    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (memread | memwrite) begin
          idx_d   = diff_c[AW+1:2];
          lane_d  = addr[1:0];
          wdata_d = write_data;
          mask_d  = sign_mask;
          is_wr_d = memwrite;
          if (!in_range_c || misaligned_c) begin
            state_d     = DONE;
            err_d       = 1'b1;
            read_data_d = 32'h0;
          end else begin
            state_d = READ;
            stall_d = 1'b1;
          end
        end
      end
      READ: begin
        if (is_wr_q) begin
          merge_d = ram_rdata_q;
          state_d = WRITE;
          stall_d = 1'b1;
        end else begin
          read_data_d = load_fmt_c;
          state_d     = DONE;
        end
      end
      WRITE: begin
        ram_we_c = 1'b1;
        state_d  = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The RAM is addressed straight from the request while idle so its data is ready in READ
  assign ram_idx_c = (state_q == IDLE) ? diff_c[AW+1:2] : idx_q;

  always_ff @(posedge clk) begin
    if (ram_we_c) mem[ram_idx_c] <= merged_c;
    else          ram_rdata_q    <= mem[ram_idx_c];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0;
      mask_q      <= 4'h0;
      is_wr_q     <= 1'b0;
      merge_q     <= 32'h0;
      read_data_q <= 32'h0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      is_wr_q     <= is_wr_d;
      merge_q     <= merge_d;
      read_data_q <= read_data_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign read_data = read_data_q;
  assign clk_stall = stall_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written multi-cycle sequences,
// and randomized accesses checked against a byte-level memory model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, write_data, read_data;
  logic        memwrite, memread, clk_stall, err;
  logic [3:0]  sign_mask;

  int errors = 0;
  int checks = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] mdl_rd;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [31:0] exp_rd;
    int          exp_stall;
    int          exp_err;
  } vec_t;

  vec_t vecs[$];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .clk_stall(clk_stall), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request, drop it after the first edge, and watch five cycles.
  task automatic run_access(input logic we, input logic re, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] m,
                            output int stalls, output int errs);
    @(negedge clk);
    memwrite = we; memread = re; addr = a; write_data = wd; sign_mask = m;
    stalls = 0; errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) begin
        memwrite = 1'b0; memread = 1'b0;
        addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom);
      end
      stalls += int'(clk_stall);
      errs   += int'(err);
    end
  endtask

  // Byte-level reference: reject, store lane bytes, or extract/extend a load value.
  task automatic model(input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] m,
                       output logic [31:0] e_rd, output int e_st, output int e_err);
    int unsigned    nb, wi, lane;
    longint unsigned v;
    nb = (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b011) ? 2 : 4;
    if (a < BASE || (a - BASE) / 4 >= DEPTH || (a % nb) != 0) begin
      mdl_rd = 32'h0; e_st = 0; e_err = 1;
    end else begin
      wi = (a - BASE) / 4;
      lane = a % 4;
      e_err = 0;
      if (we) begin
        for (int k = 0; k < int'(nb); k++) mdl[wi][8*(int'(lane)+k) +: 8] = wd[8*k +: 8];
        e_st = 2;
      end else if (re) begin
        v = (longint'(mdl[wi]) >> (8*lane)) % (64'd1 << (8*nb));
        if (m[3] && nb < 4 && v >= (64'd1 << (8*nb-1))) v = v + 64'h1_0000_0000 - (64'd1 << (8*nb));
        mdl_rd = v[31:0];
        e_st = 1;
      end else begin
        e_st = 0;
      end
    end
    e_rd = mdl_rd;
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] m,
                              input logic [31:0] rd, input int st, input int er);
    vec_t v;
    v.we = we; v.re = re; v.a = a; v.wd = wd; v.m = m;
    v.exp_rd = rd; v.exp_stall = st; v.exp_err = er;
    return v;
  endfunction

  initial begin
    int          st, er, e_st, e_er;
    logic [31:0] e_rd, rd_a, rd_b;
    logic [5:0]  pat;

    vecs.push_back(mk(1, 0, 32'h1000, 32'hDEADBEEF, 4'b0111, 32'h0,        2, 0));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,        4'b1111, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, 0, 32'h1000, 32'h11223344, 4'b0111, 32'hDEADBEEF, 2, 0));
    vecs.push_back(mk(1, 0, 32'h1003, 32'h000000F0, 4'b0001, 32'hDEADBEEF, 2, 0));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hF0223344, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1003, 32'h0,        4'b1001, 32'hFFFFFFF0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1003, 32'h0,        4'b0001, 32'h000000F0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h1004, 32'h80017FFF, 4'b0111, 32'h000000F0, 2, 0));
    vecs.push_back(mk(0, 1, 32'h1006, 32'h0,        4'b1011, 32'hFFFF8001, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1004, 32'h0,        4'b1011, 32'h00007FFF, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1002, 32'h0,        4'b1111, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 32'h1004, 32'h0,        4'b0111, 32'h80017FFF, 1, 0));
    vecs.push_back(mk(1, 0, 32'h1001, 32'h0000BEEF, 4'b0011, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hF0223344, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0FFC, 32'h0,        4'b0111, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 32'h10FC, 32'h12345678, 4'b0111, 32'h0,        2, 0));
    vecs.push_back(mk(0, 1, 32'h10FC, 32'h0,        4'b0111, 32'h12345678, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1100, 32'h0,        4'b0111, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 32'h1006, 32'h0000ABCD, 4'b0011, 32'h0,        2, 0));
    vecs.push_back(mk(0, 1, 32'h1004, 32'h0,        4'b0111, 32'hABCD7FFF, 1, 0));
    vecs.push_back(mk(1, 0, 32'h1001, 32'h0000005A, 4'b0001, 32'hABCD7FFF, 2, 0));
    vecs.push_back(mk(0, 1, 32'h1001, 32'h0,        4'b0001, 32'h0000005A, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,        4'b0111, 32'hF0225A44, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1002, 32'h0,        4'b0011, 32'h0000F022, 1, 0));

    reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
    addr = 32'h0; write_data = 32'h0; sign_mask = 4'h0;
    mdl_rd = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = 32'h0;
    #2;
    chk("reset_stall", 32'(clk_stall), 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_rd", read_data, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_access(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].m, st, er);
      model(vecs[i].we, vecs[i].re, vecs[i].a, vecs[i].wd, vecs[i].m, e_rd, e_st, e_er);
      chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
    end

    // Load held high through DONE executes twice
    @(negedge clk);
    memread = 1'b1; memwrite = 1'b0; addr = 32'h1000; sign_mask = 4'b0111;
    pat = 6'b0; rd_a = 32'h0; rd_b = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[5-i] = clk_stall;
      if (i == 1) rd_a = read_data;
      if (i == 4) rd_b = read_data;
    end
    memread = 1'b0;
    chk("held_stall_pattern", 32'(pat), 32'(6'b100100));
    chk("held_rd_first", rd_a, 32'hF0225A44);
    chk("held_rd_second", rd_b, 32'hF0225A44);

    // Both requests high behave as a store
    run_access(1, 1, 32'h1008, 32'h55555555, 4'b0111, st, er);
    model(1, 1, 32'h1008, 32'h55555555, 4'b0111, e_rd, e_st, e_er);
    chk("both_req_stall", 32'(st), 32'd2);
    run_access(0, 1, 32'h1008, 32'h0, 4'b0111, st, er);
    model(0, 1, 32'h1008, 32'h0, 4'b0111, e_rd, e_st, e_er);
    chk("both_req_rd", read_data, 32'h55555555);

    // Reset during WRITE discards the store
    @(negedge clk);
    memwrite = 1'b1; addr = 32'h1008; write_data = 32'hAAAAAAAA; sign_mask = 4'b0111;
    @(negedge clk);
    memwrite = 1'b0;
    @(negedge clk);
    chk("midwrite_stall_before", 32'(clk_stall), 32'h1);
    reset = 1'b1;
    #1;
    chk("midwrite_async_stall", 32'(clk_stall), 32'h0);
    chk("midwrite_async_err", 32'(err), 32'h0);
    chk("midwrite_async_rd", read_data, 32'h0);
    mdl_rd = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_access(0, 1, 32'h1008, 32'h0, 4'b0111, st, er);
    model(0, 1, 32'h1008, 32'h0, 4'b0111, e_rd, e_st, e_er);
    chk("after_reset_stall", 32'(st), 32'd1);
    chk("after_reset_rd", read_data, 32'h55555555);

    // Random traffic against the model, after giving every word a known value
    for (int w = 0; w < int'(DEPTH); w++) begin
      logic [31:0] d;
      d = $urandom;
      run_access(1, 0, BASE + 32'(w*4), d, 4'b0111, st, er);
      model(1, 0, BASE + 32'(w*4), d, 4'b0111, e_rd, e_st, e_er);
      chk("init_stall", 32'(st), 32'(e_st));
    end
    for (int n = 0; n < 300; n++) begin
      logic        we, re;
      logic [31:0] a, d;
      logic [3:0]  m;
      int          sz;
      we = 1'($urandom_range(0, 1));
      re = !we || ($urandom_range(0, 3) == 0);
      a  = BASE - 32'd8 + 32'($urandom_range(0, DEPTH*4 + 15));
      d  = $urandom;
      sz = $urandom_range(0, 2);
      m  = {1'($urandom_range(0, 1)), (sz == 0) ? 3'b001 : (sz == 1) ? 3'b011 : 3'b111};
      run_access(we, re, a, d, m, st, er);
      model(we, re, a, d, m, e_rd, e_st, e_er);
      chk($sformatf("rnd%0d_stall a=%h m=%b we=%b", n, a, m, we), 32'(st), 32'(e_st));
      chk($sformatf("rnd%0d_err a=%h m=%b we=%b", n, a, m, we), 32'(er), 32'(e_er));
      chk($sformatf("rnd%0d_rd a=%h m=%b we=%b", n, a, m, we), read_data, e_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
